// File: rtl/sram_pkg.sv
// Shared SRAM bus constants, device FSM encoding and helpers.
// Imported by the device model, its storage and its bus interface.
package sram_pkg;

  localparam int SRAM_AW = 18;
  localparam int SRAM_DW = 16;

  localparam logic [1:0] ST_WR   = 2'd0;
  localparam logic [1:0] ST_TURN = 2'd1;
  localparam logic [1:0] ST_RD   = 2'd2;

  typedef enum logic [1:0] {
    WR   = ST_WR,
    TURN = ST_TURN,
    RD   = ST_RD
  } state_e;

  function automatic logic [15:0] sat_inc(
    input logic [15:0] v
  );
    return (v == 16'hFFFF) ? v : v + 16'd1;
  endfunction

endpackage

// File: rtl/sram_device_model_if.sv
// Controller-to-device SRAM control bus plus device status.
// The shared data bus stays a plain inout on the device.
interface sram_device_model_if;
  import sram_pkg::*;

  logic [SRAM_AW-1:0] SRAMaddress;
  logic               SRAMWEn;
  logic               rd_valid;
  logic [15:0]        wr_count;
  logic [15:0]        rd_count;
  logic               drive_en;

  modport master (
    output SRAMaddress,
    output SRAMWEn,
    input  rd_valid,
    input  wr_count,
    input  rd_count,
    input  drive_en
  );

  modport slave (
    input  SRAMaddress,
    input  SRAMWEn,
    output rd_valid,
    output wr_count,
    output rd_count,
    output drive_en
  );

endinterface

// File: rtl/sram_array.sv
// Word storage for the SRAM device model.
// Synchronous write, asynchronous read; contents are never reset.
module sram_array
  import sram_pkg::*;
#(
  parameter int DEPTH_LOG2 = 12
) (
  input  logic                  clk_i,
  input  logic                  we_i,
  input  logic [DEPTH_LOG2-1:0] waddr_i,
  input  logic [SRAM_DW-1:0]    wdata_i,
  input  logic [DEPTH_LOG2-1:0] raddr_i,
  output logic [SRAM_DW-1:0]    rdata_o
);

  logic [SRAM_DW-1:0] mem_q [2**DEPTH_LOG2];

  always_ff @(posedge clk_i) begin
    if (we_i) begin
      mem_q[waddr_i] <= wdata_i;
    end
  end

  assign rdata_o = mem_q[raddr_i];

endmodule

// File: rtl/sram_device_model.sv
// Clocked 16-bit SRAM device with read latency and bus turnaround.
// Responds to the MEM-stage controller on a shared tristate data bus.
module sram_device_model
  import sram_pkg::*;
#(
  parameter int DEPTH_LOG2 = 12,
  parameter int READ_LAT   = 2,
  parameter int TURNAROUND = 1
) (
  input  logic               clk,
  input  logic               rst,
  inout  wire  [SRAM_DW-1:0] SRAMdata,
  sram_device_model_if.slave bus
);

  localparam logic [2:0] LAT_MAX  = 3'(READ_LAT - 1);
  localparam logic [1:0] TURN_MAX =
    2'((TURNAROUND == 0) ? 0 : TURNAROUND - 1);

  state_e             state_q, state_d;
  logic [1:0]         turn_q, turn_d;
  logic [2:0]         lat_q, lat_d;
  logic [SRAM_AW-1:0] addr_q;
  logic [SRAM_DW-1:0] out_q, out_d;
  logic               vld_q, vld_d;
  logic [15:0]        wrc_q, wrc_d;
  logic [15:0]        rdc_q, rdc_d;
  logic [SRAM_DW-1:0] rdata;
  logic               we;
  logic               drive_en;

  // a write on the edge that also sees reset is dropped
  assign we = ~bus.SRAMWEn & ~rst;

  sram_array #(
    .DEPTH_LOG2(DEPTH_LOG2)
  ) u_array (
    .clk_i  (clk),
    .we_i   (we),
    .waddr_i(bus.SRAMaddress[DEPTH_LOG2-1:0]),
    .wdata_i(SRAMdata),
    .raddr_i(bus.SRAMaddress[DEPTH_LOG2-1:0]),
    .rdata_o(rdata)
  );

  always_comb begin
    state_d = state_q;
    turn_d  = turn_q;
    lat_d   = lat_q;
    out_d   = out_q;
    vld_d   = vld_q;
    wrc_d   = wrc_q;
    rdc_d   = rdc_q;
    if (!bus.SRAMWEn) begin
      state_d = WR;
      vld_d   = 1'b0;
      wrc_d   = sat_inc(wrc_q);
    end else begin
      unique case (state_q)
        WR: begin
          turn_d  = 2'd0;
          lat_d   = 3'd0;
          state_d = (TURNAROUND == 0) ? RD : TURN;
        end
        TURN: begin
          if (TURNAROUND == 0 || turn_q == TURN_MAX) begin
            state_d = RD;
            lat_d   = 3'd0;
          end else begin
            turn_d = turn_q + 2'd1;
          end
        end
        RD: begin
          if (bus.SRAMaddress != addr_q) begin
            lat_d = 3'd0;
            vld_d = 1'b0;
          end else if (lat_q == LAT_MAX) begin
            out_d = rdata;
            vld_d = 1'b1;
          end else begin
            lat_d = lat_q + 3'd1;
          end
        end
        default: state_d = TURN;
      endcase
    end
    if (vld_d && !vld_q) begin
      rdc_d = sat_inc(rdc_q);
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q <= TURN;
      turn_q  <= 2'd0;
      lat_q   <= 3'd0;
      addr_q  <= '0;
      out_q   <= '0;
      vld_q   <= 1'b0;
      wrc_q   <= 16'd0;
      rdc_q   <= 16'd0;
    end else begin
      state_q <= state_d;
      turn_q  <= turn_d;
      lat_q   <= lat_d;
      addr_q  <= bus.SRAMaddress;
      out_q   <= out_d;
      vld_q   <= vld_d;
      wrc_q   <= wrc_d;
      rdc_q   <= rdc_d;
    end
  end

  // released combinationally the moment SRAMWEn falls
  assign drive_en     = (state_q == RD) & bus.SRAMWEn;
  assign SRAMdata     = drive_en ? out_q : 16'hzzzz;
  assign bus.drive_en = drive_en;
  assign bus.rd_valid = vld_q;
  assign bus.wr_count = wrc_q;
  assign bus.rd_count = rdc_q;

endmodule

// File: tb/tb_sram_device_model.sv
// Bench for sram_device_model: directed and random traffic
// against a cycle-count reference of the device timing.
module tb_sram_device_model;
  import sram_pkg::*;

  localparam int DL = 12;
  localparam int RL = 2;
  localparam int TA = 1;

  logic clk = 1'b0;
  logic rst = 1'b1;
  always #5 clk = ~clk;

  sram_device_model_if bus();

  wire  [15:0] SRAMdata;
  logic        tb_drv;
  logic [15:0] tb_wd;
  assign SRAMdata = tb_drv ? tb_wd : 16'hzzzz;

  sram_device_model #(
    .DEPTH_LOG2(DL),
    .READ_LAT  (RL),
    .TURNAROUND(TA)
  ) dut (
    .clk     (clk),
    .rst     (rst),
    .SRAMdata(SRAMdata),
    .bus     (bus)
  );

  int total = 0;
  int bad   = 0;

  logic [15:0] m_mem [2**DL];
  int          m_k;
  bit          m_arst;
  bit          m_in_rd;
  int          m_s;
  bit          m_vld;
  logic [15:0] m_last;
  int          m_wrc;
  int          m_rdc;
  logic [17:0] m_prev;

  task automatic chk(input string tag,
                     input logic [31:0] obs,
                     input logic [31:0] exp);
    total++;
    assert (obs === exp) else begin
      bad++;
      $error("FAIL %s observed=%0h expected=%0h",
             tag, obs, exp);
    end
  endtask

  task automatic m_reset();
    m_k     = 0;
    m_arst  = 1'b1;
    m_in_rd = 1'b0;
    m_s     = 0;
    m_vld   = 1'b0;
    m_last  = 16'h0000;
    m_wrc   = 0;
    m_rdc   = 0;
    m_prev  = '0;
  endtask

  // k = edges with WEn high since last write (or reset);
  // s = stable-address edges since entering read or last change
  task automatic m_edge(input logic wen,
                        input logic [17:0] a,
                        input logic [15:0] d);
    bit nv;
    int entry;
    if (!wen) begin
      m_mem[a[DL-1:0]] = d;
      if (m_wrc < 65535) m_wrc++;
      m_k     = 0;
      m_arst  = 1'b0;
      m_in_rd = 1'b0;
      m_vld   = 1'b0;
    end else begin
      m_k++;
      entry = m_arst ? ((TA > 1) ? TA : 1) : TA + 1;
      if (!m_in_rd) begin
        if (m_k >= entry) begin
          m_in_rd = 1'b1;
          m_s     = 0;
        end
      end else if (a != m_prev) begin
        m_s = 0;
      end else if (m_s < 100) begin
        m_s++;
      end
      nv = m_in_rd && (m_s >= RL);
      if (nv && !m_vld && m_rdc < 65535) m_rdc++;
      if (nv) m_last = m_mem[a[DL-1:0]];
      m_vld = nv;
    end
    m_prev = a;
  endtask

  task automatic step(input logic wen,
                      input logic [17:0] a,
                      input logic [15:0] d,
                      input bit check);
    bus.SRAMWEn     = wen;
    bus.SRAMaddress = a;
    tb_drv          = !wen;
    tb_wd           = d;
    #1;
    if (check) chk("drive_en", 32'(bus.drive_en),
                   32'(m_in_rd && wen));
    @(posedge clk);
    m_edge(wen, a, d);
    @(negedge clk);
    if (check) begin
      chk("rd_valid", 32'(bus.rd_valid), 32'(m_vld));
      chk("wr_count", 32'(bus.wr_count), 32'(m_wrc));
      chk("rd_count", 32'(bus.rd_count), 32'(m_rdc));
      if (m_in_rd && wen)
        chk("rd_data", 32'(SRAMdata), 32'(m_last));
    end
  endtask

  logic [17:0] ra;
  int          r0;

  initial begin
    bus.SRAMWEn     = 1'b1;
    bus.SRAMaddress = '0;
    tb_drv          = 1'b0;
    tb_wd           = '0;
    m_reset();
    repeat (2) @(negedge clk);
    chk("rst_valid", 32'(bus.rd_valid), 32'd0);
    chk("rst_wrc", 32'(bus.wr_count), 32'd0);
    chk("rst_rdc", 32'(bus.rd_count), 32'd0);
    chk("rst_hiz", 32'(bus.drive_en), 32'd0);
    rst = 1'b0;

    // reset in the middle of a read
    step(1'b0, 18'h5, 16'hC0DE, 1'b1);
    repeat (4) step(1'b1, 18'h5, 16'h0, 1'b1);
    chk("t1_pre_valid", 32'(bus.rd_valid), 32'd1);
    chk("t1_pre_drive", 32'(bus.drive_en), 32'd1);
    #2 rst = 1'b1;
    #1;
    chk("t1_hiz", 32'(bus.drive_en), 32'd0);
    chk("t1_valid", 32'(bus.rd_valid), 32'd0);
    chk("t1_wrc", 32'(bus.wr_count), 32'd0);
    chk("t1_rdc", 32'(bus.rd_count), 32'd0);
    m_reset();
    @(negedge clk);
    rst = 1'b0;
    repeat (4) step(1'b1, 18'h5, 16'h0, 1'b1);
    chk("t1_kept", 32'(SRAMdata), 32'h0000C0DE);

    // write then read with turnaround and latency
    step(1'b0, 18'h10, 16'hBEEF, 1'b1);
    step(1'b1, 18'h10, 16'h0, 1'b1);
    chk("t2_turn_hiz", 32'(bus.drive_en), 32'd0);
    step(1'b1, 18'h10, 16'h0, 1'b1);
    step(1'b1, 18'h10, 16'h0, 1'b1);
    chk("t2_notyet", 32'(bus.rd_valid), 32'd0);
    step(1'b1, 18'h10, 16'h0, 1'b1);
    chk("t2_valid", 32'(bus.rd_valid), 32'd1);
    chk("t2_data", 32'(SRAMdata), 32'h0000BEEF);

    // back-to-back reads with an address change
    step(1'b0, 18'h20, 16'hA5A5, 1'b1);
    step(1'b0, 18'h21, 16'h5A5A, 1'b1);
    repeat (4) step(1'b1, 18'h20, 16'h0, 1'b1);
    chk("t3_a5", 32'(SRAMdata), 32'h0000A5A5);
    step(1'b1, 18'h21, 16'h0, 1'b1);
    chk("t3_drop", 32'(bus.rd_valid), 32'd0);
    step(1'b1, 18'h21, 16'h0, 1'b1);
    chk("t3_wait", 32'(bus.rd_valid), 32'd0);
    step(1'b1, 18'h21, 16'h0, 1'b1);
    chk("t3_valid", 32'(bus.rd_valid), 32'd1);
    chk("t3_5a", 32'(SRAMdata), 32'h00005A5A);

    // WEn falls while the device drives
    bus.SRAMWEn = 1'b0;
    tb_drv      = 1'b1;
    tb_wd       = 16'h7777;
    #1;
    chk("t4_release", 32'(bus.drive_en), 32'd0);
    chk("t4_bus", 32'(SRAMdata), 32'h00007777);
    @(posedge clk);
    m_edge(1'b0, 18'h21, 16'h7777);
    @(negedge clk);
    chk("t4_valid", 32'(bus.rd_valid), 32'd0);
    repeat (4) step(1'b1, 18'h21, 16'h0, 1'b1);
    chk("t4_new", 32'(SRAMdata), 32'h00007777);

    // upper address bits alias
    step(1'b0, 18'h01003, 16'h1234, 1'b1);
    repeat (4) step(1'b1, 18'h00003, 16'h0, 1'b1);
    chk("t5_alias", 32'(SRAMdata), 32'h00001234);

    // random traffic over an aliased pool
    for (int i = 0; i < 8; i++)
      step(1'b0, 18'h040 + 18'(i), 16'($urandom), 1'b1);
    ra = 18'h040;
    for (int i = 0; i < 400; i++) begin
      if ($urandom_range(0, 3) == 0)
        ra = {6'($urandom_range(0, 63)),
              12'h040 + 12'($urandom_range(0, 7))};
      if ($urandom_range(0, 9) < 2)
        step(1'b0, ra, 16'($urandom), 1'b1);
      else
        step(1'b1, ra, 16'h0, 1'b1);
    end

    // write counter saturation
    for (int i = 0; i < 70000; i++)
      step(1'b0, 18'($urandom), 16'($urandom), 1'b0);
    chk("t6_sat", 32'(bus.wr_count), 32'h0000FFFF);
    step(1'b0, 18'h5, 16'h4242, 1'b1);
    chk("t6_hold", 32'(bus.wr_count), 32'h0000FFFF);
    r0 = m_rdc;
    repeat (6) step(1'b1, 18'h5, 16'h0, 1'b1);
    chk("t6_rdc", 32'(bus.rd_count), 32'(r0 + 1));
    chk("t6_data", 32'(SRAMdata), 32'h00004242);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
